// File: rtl/mc_ctrl_if.sv
// Control bundle between the multi-cycle sequencer (master) and the
// MIPS-subset datapath (slave).
interface mc_ctrl_if #(
  parameter int unsigned RETIRE_CNT_W = 32
);
  logic [5:0]              Op;
  logic [5:0]              Funct;
  logic                    Zero;
  logic                    mem_rdy;
  logic                    PCWrite;
  logic                    IRWrite;
  logic                    RegWrite;
  logic                    MemRead;
  logic                    MemWrite;
  logic                    IorD;
  logic                    EXTOp;
  logic [2:0]              ALUOp;
  logic [1:0]              NPCOp;
  logic                    ALUSrc;
  logic                    GPRSel;
  logic                    WDSel;
  logic [2:0]              state;
  logic                    illegal;
  logic                    retire;
  logic [RETIRE_CNT_W-1:0] retire_cnt;

  modport master (
    input  Op, Funct, Zero, mem_rdy,
    output PCWrite, IRWrite, RegWrite, MemRead, MemWrite, IorD, EXTOp,
           ALUOp, NPCOp, ALUSrc, GPRSel, WDSel, state, illegal, retire,
           retire_cnt
  );

  modport slave (
    output Op, Funct, Zero, mem_rdy,
    input  PCWrite, IRWrite, RegWrite, MemRead, MemWrite, IorD, EXTOp,
           ALUOp, NPCOp, ALUSrc, GPRSel, WDSel, state, illegal, retire,
           retire_cnt
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle FETCH/DECODE/EXE/MEM/WB control sequencer for the MIPS-subset
// CPU, with memory-ready stalls and a retired-instruction counter.
module mc_ctrl #(
  parameter int unsigned RETIRE_CNT_W = 32
) (
  input  logic      clk,
  input  logic      rstn,
  mc_ctrl_if.master bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  localparam logic [2:0] ALU_NOP  = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;

  localparam logic [1:0] NPC_PLUS4  = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH  = 3'b000,
    S_DECODE = 3'b001,
    S_EXE    = 3'b010,
    S_MEM    = 3'b011,
    S_WB     = 3'b100
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [RETIRE_CNT_W-1:0] retire_cnt_q;

  logic       legal;
  logic       is_lw;
  logic       is_sw;
  logic       is_beq;
  logic       is_j;
  logic       rt_dest;
  logic [2:0] dec_alu_op;
  logic       dec_alu_src;
  logic       dec_ext_op;

  logic       pc_write;
  logic       ir_write;
  logic       reg_write;
  logic       mem_read;
  logic       mem_write;
  logic       iord;
  logic       ext_op;
  logic [2:0] alu_op;
  logic [1:0] npc_op;
  logic       alu_src;
  logic       gpr_sel;
  logic       wd_sel;
  logic       illegal;
  logic       retire;

  // Instruction decode from the IR opcode/funct fields.
  always_comb begin
    legal       = 1'b1;
    dec_alu_op  = ALU_NOP;
    dec_alu_src = 1'b0;
    dec_ext_op  = 1'b0;
    is_lw       = (bus.Op == OP_LW);
    is_sw       = (bus.Op == OP_SW);
    is_beq      = (bus.Op == OP_BEQ);
    is_j        = (bus.Op == OP_J);
    rt_dest     = (bus.Op == OP_LW) || (bus.Op == OP_ADDI) || (bus.Op == OP_ORI);
    case (bus.Op)
      OP_RTYPE: begin
        case (bus.Funct)
          FN_ADD, FN_ADDU: dec_alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: dec_alu_op = ALU_SUB;
          FN_AND:          dec_alu_op = ALU_AND;
          FN_OR:           dec_alu_op = ALU_OR;
          FN_SLT:          dec_alu_op = ALU_SLT;
          FN_SLTU:         dec_alu_op = ALU_SLTU;
          default:         legal      = 1'b0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: begin
        dec_alu_op  = ALU_ADD;
        dec_alu_src = 1'b1;
        dec_ext_op  = 1'b1;
      end
      OP_ORI: begin
        dec_alu_op  = ALU_OR;
        dec_alu_src = 1'b1;
      end
      OP_BEQ:  dec_alu_op = ALU_SUB;
      OP_J:    dec_alu_op = ALU_NOP;
      default: legal      = 1'b0;
    endcase
  end

  // Next-state and control outputs; everything is forced low while in reset.
  always_comb begin
    state_d   = state_q;
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    iord      = 1'b0;
    ext_op    = 1'b0;
    alu_op    = ALU_NOP;
    npc_op    = NPC_PLUS4;
    alu_src   = 1'b0;
    gpr_sel   = 1'b0;
    wd_sel    = 1'b0;
    illegal   = 1'b0;
    retire    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        if (bus.mem_rdy) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!legal) begin
          illegal = 1'b1;
          state_d = S_FETCH;
        end else if (is_j) begin
          pc_write = 1'b1;
          npc_op   = NPC_JUMP;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        alu_op  = dec_alu_op;
        alu_src = dec_alu_src;
        ext_op  = dec_ext_op;
        if (is_beq) begin
          pc_write = bus.Zero;
          npc_op   = NPC_BRANCH;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        iord    = 1'b1;
        alu_op  = dec_alu_op;
        alu_src = dec_alu_src;
        ext_op  = dec_ext_op;
        if (is_lw) begin
          mem_read = 1'b1;
          if (bus.mem_rdy) state_d = S_WB;
        end else if (is_sw) begin
          mem_write = 1'b1;
          if (bus.mem_rdy) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end else begin
          state_d = S_FETCH;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        gpr_sel   = rt_dest;
        wd_sel    = is_lw;
        state_d   = S_FETCH;
        if (!is_lw) begin
          alu_op  = dec_alu_op;
          alu_src = dec_alu_src;
          ext_op  = dec_ext_op;
        end
      end
      default: state_d = S_FETCH;
    endcase
    if (!rstn) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      iord      = 1'b0;
      ext_op    = 1'b0;
      alu_op    = ALU_NOP;
      npc_op    = NPC_PLUS4;
      alu_src   = 1'b0;
      gpr_sel   = 1'b0;
      wd_sel    = 1'b0;
      illegal   = 1'b0;
      retire    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Retired-instruction counter, wraps naturally at 2^RETIRE_CNT_W.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       retire_cnt_q <= '0;
    else if (retire) retire_cnt_q <= retire_cnt_q + RETIRE_CNT_W'(1);
  end

  assign bus.PCWrite    = pc_write;
  assign bus.IRWrite    = ir_write;
  assign bus.RegWrite   = reg_write;
  assign bus.MemRead    = mem_read;
  assign bus.MemWrite   = mem_write;
  assign bus.IorD       = iord;
  assign bus.EXTOp      = ext_op;
  assign bus.ALUOp      = alu_op;
  assign bus.NPCOp      = npc_op;
  assign bus.ALUSrc     = alu_src;
  assign bus.GPRSel     = gpr_sel;
  assign bus.WDSel      = wd_sel;
  assign bus.state      = state_q;
  assign bus.illegal    = illegal;
  assign bus.retire     = retire;
  assign bus.retire_cnt = retire_cnt_q;

endmodule
